// File: rtl/vga_fb_arbiter.sv
// Frame-memory port arbiter: VGA scan-out reads own the port in the active area,
// and a single drawing-engine writer is served in blanking slots. Optional VGA_ARB_CLIP_EN drops out-of-range writes.
module vga_fb_arbiter #(
  parameter logic [9:0]  H_START  = 10'd144,
  parameter logic [9:0]  H_ACTIVE = 10'd640,
  parameter logic [9:0]  V_START  = 10'd35,
  parameter logic [9:0]  V_ACTIVE = 10'd480,
  parameter int unsigned DW       = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [19:0]   iAddr,
  input  logic          iWrReq,
  input  logic [9:0]    iWrX,
  input  logic [9:0]    iWrY,
  input  logic [DW-1:0] iWrData,
  output logic          oWrAck,
  output logic [18:0]   oMemAddr,
  output logic          oMemWe,
  output logic [DW-1:0] oMemWData,
  input  logic [DW-1:0] iMemRData,
  output logic [DW-1:0] oPixel
);

  localparam int unsigned CW = 10;
  localparam int unsigned XW = CW + 1;
  localparam int unsigned AW = 19;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic [CW-1:0] w_px;
  logic [CW-1:0] w_py;
  logic [XW-1:0] w_h_end;
  logic [XW-1:0] w_v_end;
  logic          w_h_in;
  logic          w_v_in;
  logic          w_active;
  logic [AW-1:0] w_scan_addr;
  logic [AW-1:0] w_wr_addr;
  logic          w_wr_in_range;

  logic [AW-1:0] w_mem_addr_d;
  logic          w_mem_we_d;
  logic [DW-1:0] w_mem_wdata_d;
  logic          w_wr_ack_d;

  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_wdata;
  logic          r_wr_ack;
  logic          r_act_s1;
  logic          r_act_s2;
  logic [DW-1:0] r_pixel;

  // Active-area decode on the raw timing counters
  assign w_x     = iAddr[19:10];
  assign w_y     = iAddr[9:0];
  assign w_h_end = XW'(H_START) + XW'(H_ACTIVE);
  assign w_v_end = XW'(V_START) + XW'(V_ACTIVE);
  assign w_h_in  = ({1'b0, w_x} >= XW'(H_START)) && ({1'b0, w_x} < w_h_end);
  assign w_v_in  = ({1'b0, w_y} >= XW'(V_START)) && ({1'b0, w_y} < w_v_end);
  assign w_active = w_h_in && w_v_in;

  // Upper row/col bits are intentionally truncated into the 19-bit address
  assign w_px        = w_x - H_START;
  assign w_py        = w_y - V_START;
  assign w_scan_addr = AW'({w_py, w_px});
  assign w_wr_addr   = AW'({iWrY, iWrX});

`ifdef VGA_ARB_CLIP_EN
  assign w_wr_in_range = (iWrX < H_ACTIVE) && (iWrY < V_ACTIVE);
`else
  assign w_wr_in_range = 1'b1;
`endif

  // Write FSM state register
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write FSM next state; a write may only take a non-active slot
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (iWrReq) begin
          w_next_state = w_active ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (!iWrReq) begin
          w_next_state = S_IDLE;
        end else if (!w_active) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Port owner for the stage-1 slot: scan read, write issue, or idle hold
  always_comb begin
    w_mem_addr_d  = r_mem_addr;
    w_mem_we_d    = 1'b0;
    w_mem_wdata_d = r_mem_wdata;
    w_wr_ack_d    = 1'b0;
    if (w_active) begin
      w_mem_addr_d = w_scan_addr;
    end else if (w_next_state == S_ISSUE) begin
      w_mem_addr_d  = w_wr_addr;
      w_mem_wdata_d = iWrData;
      w_mem_we_d    = w_wr_in_range;
      w_wr_ack_d    = 1'b1;
    end
  end

  // Stage-1 port registers
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
    end else begin
      r_mem_addr  <= w_mem_addr_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_wr_ack    <= w_wr_ack_d;
    end
  end

  // Active flag follows the read through address, memory and pixel stages
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_act_s1 <= 1'b0;
      r_act_s2 <= 1'b0;
      r_pixel  <= '0;
    end else begin
      r_act_s1 <= w_active;
      r_act_s2 <= r_act_s1;
      r_pixel  <= r_act_s2 ? iMemRData : '0;
    end
  end

  assign oMemAddr  = r_mem_addr;
  assign oMemWe    = r_mem_we;
  assign oMemWData = r_mem_wdata;
  assign oWrAck    = r_wr_ack;
  assign oPixel    = r_pixel;

endmodule
